// File: rtl/phy_rx_sp.sv
// Receive-side serial-to-parallel stage: locks byte alignment on a comma train,
// then deals the recovered byte stream round-robin onto four registered lanes.
module phy_rx_sp #(
  parameter logic [7:0] COMMA   = 8'hBC,
  parameter int         N_COMMA = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_sp,
  output logic       active,
  output logic [7:0] Out0,
  output logic [7:0] Out1,
  output logic [7:0] Out2,
  output logic [7:0] Out3,
  output logic       validOut0,
  output logic       validOut1,
  output logic       validOut2,
  output logic       validOut3
);

  localparam int CW = $clog2(N_COMMA + 1);

  typedef enum logic [1:0] {SEARCH, COUNT, ALIGNED} state_t;

  state_t          state, state_nx;
  logic [7:0]      sr;
  logic [2:0]      bit_cnt, bit_cnt_nx;
  logic [CW-1:0]   comma_cnt, comma_cnt_nx;
  logic [1:0]      lane, lane_nx;
  logic            active_nx;
  logic [3:0][7:0] out_q, out_nx;
  logic [3:0]      valid_q, valid_nx;
  logic            boundary;
  logic            is_comma;

  assign boundary = (bit_cnt == 3'd0);
  assign is_comma = (sr == COMMA);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      lane      <= '0;
      active    <= 1'b0;
      out_q     <= '0;
      valid_q   <= '0;
    end else begin
      state     <= state_nx;
      sr        <= {sr[6:0], in_sp};
      bit_cnt   <= bit_cnt_nx;
      comma_cnt <= comma_cnt_nx;
      lane      <= lane_nx;
      active    <= active_nx;
      out_q     <= out_nx;
      valid_q   <= valid_nx;
    end
  end

  // The first comma may sit at any bit offset; after that only byte boundaries matter.
  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    comma_cnt_nx = comma_cnt;
    lane_nx      = lane;
    active_nx    = active;
    out_nx       = out_q;
    valid_nx     = valid_q;
    case (state)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_nx   = 3'd1;
          comma_cnt_nx = CW'(1);
          state_nx     = COUNT;
        end
      end
      COUNT: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nx = comma_cnt + CW'(1);
            if (comma_cnt_nx == CW'(N_COMMA)) begin
              state_nx  = ALIGNED;
              active_nx = 1'b1;
              lane_nx   = 2'd0;
            end
          end else begin
            comma_cnt_nx = '0;
            state_nx     = SEARCH;
          end
        end
      end
      ALIGNED: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          out_nx[lane]   = sr;
          valid_nx[lane] = !is_comma;
          lane_nx        = lane + 2'd1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  assign Out0      = out_q[0];
  assign Out1      = out_q[1];
  assign Out2      = out_q[2];
  assign Out3      = out_q[3];
  assign validOut0 = valid_q[0];
  assign validOut1 = valid_q[1];
  assign validOut2 = valid_q[2];
  assign validOut3 = valid_q[3];

endmodule

// File: doc/phy_rx_sp.md
# phy_rx_sp

Receive-side serial-to-parallel block for the 4-lane PHY link. It sits at the far end of the serial line driven by phy_tx and consumes one bit per clk_32f cycle, MSB first. It finds byte alignment from a comma train, then de-interleaves the byte stream round-robin onto four 8-bit lanes, each with its own valid flag. It is the counterpart of phy_tx's lane mux and parallel-to-serial stage.

## Interface
- COMMA, 8'hBC, alignment/idle symbol; a slot carrying it is an invalid slot
- N_COMMA, 4, consecutive byte-aligned commas required to declare alignment
- clk_32f  input  1  bit clock; all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- in_sp  input  1  serial data from phy_tx, MSB of each byte first
- active  output  1  high while aligned
- Out0..Out3  output  8 each  recovered lane bytes (registered)
- validOut0..validOut3  output  1 each  lane valid flags (registered)

## Operation
- One clock and one reset. Reset is asynchronous and active-low.
- Reset value of every register is 0:
  - sr, bit_cnt, comma_cnt, lane and all outputs are 0.
  - The state is SEARCH.
- Shift register:
  - Every cycle, sr <= {sr[6:0], in_sp}.
  - Checks below use the registered sr.
- State SEARCH:
  - Every cycle, compare sr with COMMA (sliding window).
  - On a match: bit_cnt <= 1, comma_cnt <= 1, go to COUNT.
- State COUNT:
  - bit_cnt increments mod 8.
  - A boundary is a cycle with bit_cnt == 0; sr then holds a full byte.
  - At a boundary with sr == COMMA: comma_cnt++.
  - When comma_cnt reaches N_COMMA: go to ALIGNED, active <= 1, lane <= 0.
  - At a boundary with sr != COMMA: go to SEARCH, comma_cnt <= 0.
- State ALIGNED:
  - At each boundary:
    - Out[lane] <= sr.
    - validOut[lane] <= (sr != COMMA).
    - lane <= lane + 1 mod 4.
  - Between boundaries, outputs hold.
  - Each lane's output and valid hold for 32 cycles, until that lane's next slot.
- No loss-of-lock detection: ALIGNED is left only through reset. Commas in ALIGNED are just invalid slots.
- Outputs in SEARCH or COUNT:
  - active = 0 and all validOut = 0.
  - Out registers keep their reset or last value.

## Timing
- Bit k of the serial stream is sampled at edge k.
- A byte completed at edge N is in sr after edge N (boundary cycle).
- That byte lands in Out/validOut after edge N+1: latency 1 cycle from its last bit.
- Alignment:
  - The first comma is detected the cycle after its last bit is shifted in.
  - active rises 1 cycle after the N_COMMA-th comma's boundary.
- The first lane-0 slot is the boundary 8 cycles after the N_COMMA-th comma's boundary.
- Lane k updates 8·k cycles after lane 0; the pattern repeats every 32 cycles.
- A comma split across the window mid-COUNT is ignored; only boundary bytes count.
- Reset asserted mid-frame clears everything immediately (asynchronous). After release, re-alignment needs a fresh N_COMMA comma train.

## Test plan
- Reset check: hold reset=0 for 5 cycles -> active=0, all Out=8'h00, all validOut=0, even with in_sp toggling.
- Alignment with offset: send 3 junk bits (101), then 4×8'hBC, then 8'h11,22,33,44 -> active rises 1 cycle after the 4th comma boundary. Then Out0=11, Out1=22, Out2=33, Out3=44, all valid=1. Each value appears 1 cycle after its last bit.
- Broken comma train: send 3×BC, 8'h55, then 3×BC -> active stays 0. A further single BC (4 consecutive) -> active=1.
- Invalid slot: aligned stream 8'hA0, BC, A2, A3 -> validOut0=1 (Out0=A0), validOut1=0 with Out1=8'hBC, validOut2=1, validOut3=1. Flags are held 32 cycles.
- Wrap-around: send two aligned frames 01..04, then 05..08 -> lane 0 goes 01→05 exactly 32 cycles apart; no lane skipped or duplicated.
- Reset mid-operation: assert reset during the lane-2 byte of an aligned frame -> all outputs and active drop to 0 immediately. After release, the data bytes alone do not re-align; a new 4×BC train is required.
